// File: rtl/cobra_run_ctrl.sv
// Run-control sequencer for the CYBERcobra core: gates every PC/RF commit through
// core_en_o and provides run, halt, single-step, breakpoint and end-of-program stop.
module cobra_run_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_req_i,
  input  logic              halt_req_i,
  input  logic              step_req_i,
  input  logic              bp_en_i,
  input  logic [ADDR_W-1:0] bp_addr_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [31:0]       instr_i,
  output logic              core_en_o,
  output logic [1:0]        state_o,
  output logic              halted_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  instr_cnt_o
);

  localparam logic [1:0] ST_HALT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bp_skip_q, bp_skip_d;

  logic bp_hit, end_hit, stop_run, core_en;

  assign bp_hit   = bp_en_i & (pc_i == bp_addr_i);
  // A J with offset 0 is a self-loop: the program can make no further progress.
  assign end_hit  = instr_i[31] & (instr_i[12:5] == 8'd0);
  assign stop_run = halt_req_i | end_hit | (bp_hit & ~bp_skip_q);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    core_en = 1'b0;
    unique case (state_q)
      ST_RUN:  core_en = ~stop_run;
      ST_STEP: core_en = ~end_hit;
      default: core_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    bp_skip_d = bp_skip_q;
    unique case (state_q)
      ST_HALT: begin
        // halt_req_i in HALT is a no-op, but it still blocks a same-cycle step/run.
        if (!halt_req_i && (step_req_i || run_req_i)) begin
          state_d   = step_req_i ? ST_STEP : ST_RUN;
          bp_skip_d = bp_hit;
        end
      end
      ST_RUN: begin
        if (end_hit)                                   state_d = ST_DONE;
        else if (halt_req_i || (bp_hit && !bp_skip_q)) state_d = ST_HALT;
      end
      ST_STEP: state_d = end_hit ? ST_DONE : ST_HALT;
      default: state_d = ST_DONE;
    endcase
    if (core_en) bp_skip_d = 1'b0;
  end

  // Saturating retire counter: it sticks at all-ones rather than wrapping.
  assign cnt_d = (core_en && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      state_q   <= ST_HALT;
      cnt_q     <= '0;
      bp_skip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bp_skip_q <= bp_skip_d;
    end
  end

  assign core_en_o   = core_en;
  assign state_o     = state_q;
  assign halted_o    = (state_q == ST_HALT) || (state_q == ST_DONE);
  assign done_o      = (state_q == ST_DONE);
  assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_cobra_run_ctrl.sv
// Scoreboard bench for cobra_run_ctrl: a cycle-level reference model predicts each
// cycle's outputs into a queue, and a negedge monitor pops and compares them.
module tb_cobra_run_ctrl;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          run_req_i = 1'b0, halt_req_i = 1'b0, step_req_i = 1'b0;
  logic          bp_en_i = 1'b0;
  logic [31:0]   bp_addr_i = '0, pc_i = '0, instr_i = '0;
  logic          core_en_o, halted_o, done_o;
  logic [1:0]    state_o;
  logic [CW-1:0] instr_cnt_o;

  cobra_run_ctrl #(.ADDR_W(32), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_req_i(run_req_i), .halt_req_i(halt_req_i),
    .step_req_i(step_req_i), .bp_en_i(bp_en_i), .bp_addr_i(bp_addr_i), .pc_i(pc_i),
    .instr_i(instr_i), .core_en_o(core_en_o), .state_o(state_o), .halted_o(halted_o),
    .done_o(done_o), .instr_cnt_o(instr_cnt_o)
  );

  always #5 clk = ~clk;

  typedef enum {M_HALT, M_RUN, M_STEP, M_DONE} mode_t;
  typedef struct packed {
    logic          en;
    logic [1:0]    st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] imem [64];

  mode_t       m_mode;
  int          m_cnt;
  bit          m_skip;
  logic [31:0] m_pc;

  function automatic logic [1:0] enc(input mode_t m);
    case (m)
      M_RUN:   return 2'b01;
      M_STEP:  return 2'b10;
      M_DONE:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_i && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("core_en", 32'(core_en_o), 32'(e.en));
      check("state",   32'(state_o),   32'(e.st));
      check("halted",  32'(halted_o),  32'((e.st == 2'b00) || (e.st == 2'b11)));
      check("done",    32'(done_o),    32'(e.st == 2'b11));
      check("cnt",     32'(instr_cnt_o), 32'(e.cnt));
    end
  end

  // One clock cycle: drive requests plus the "core" PC/instruction, predict, advance.
  task automatic tick(input bit r, input bit h, input bit s);
    logic [31:0] ins;
    bit bp, eh, en;
    exp_t e;
    ins = imem[m_pc[7:2]];
    run_req_i = r; halt_req_i = h; step_req_i = s;
    pc_i = m_pc; instr_i = ins;
    bp = bp_en_i && (m_pc == bp_addr_i);
    eh = ins[31] && (ins[12:5] == 8'd0);
    case (m_mode)
      M_RUN:   en = !(h || eh || (bp && !m_skip));
      M_STEP:  en = !eh;
      default: en = 1'b0;
    endcase
    e.en = en; e.st = enc(m_mode); e.cnt = CW'(m_cnt);
    q.push_back(e);
    case (m_mode)
      M_HALT: if (!h && (s || r)) begin
        m_mode = s ? M_STEP : M_RUN;
        m_skip = bp;
      end
      M_RUN:  if (eh) m_mode = M_DONE; else if (h || (bp && !m_skip)) m_mode = M_HALT;
      M_STEP: m_mode = eh ? M_DONE : M_HALT;
      default: ;
    endcase
    if (en) begin
      m_skip = 1'b0;
      m_cnt  = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      m_pc   = m_pc + 32'd4;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    run_req_i = 1'b0; halt_req_i = 1'b0; step_req_i = 1'b0;
    m_mode = M_HALT; m_cnt = 0; m_skip = 1'b0; m_pc = '0;
    q.delete();
    #1;
    check("rst_state",  32'(state_o), 32'd0);
    check("rst_en",     32'(core_en_o), 32'd0);
    check("rst_halted", 32'(halted_o), 32'd1);
    check("rst_done",   32'(done_o), 32'd0);
    check("rst_cnt",    32'(instr_cnt_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
  endtask

  // Non-end program; includes near-miss J words that must not stop execution.
  task automatic fill_clean();
    for (int i = 0; i < 64; i++) imem[i] = $urandom & 32'h7FFF_FFFF;
    imem[2] = 32'h8000_0020;
    imem[3] = 32'h0000_0000;
    imem[5] = 32'h8000_1000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_clean();
    @(posedge clk); #1;
    do_reset();
    idle(5);
    check("idle_cnt", 32'(instr_cnt_o), 32'd0);

    // Free run, halt after 10 retirements.
    tick(1, 0, 0);
    idle(10);
    tick(0, 1, 0);
    check("halt_state", 32'(state_o), 32'd0);
    check("halt_cnt",   32'(instr_cnt_o), 32'd10);
    idle(3);

    // Counter saturation on a long run.
    do_reset();
    tick(1, 0, 0);
    idle(20);
    check("sat_cnt", 32'(instr_cnt_o), 32'(CMAX));

    // Three single steps spaced 4 cycles apart.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, 1);
      idle(3);
    end
    check("step_cnt",   32'(instr_cnt_o), 32'd3);
    check("step_state", 32'(state_o), 32'd0);

    // Breakpoint at 0x10, then resume past it.
    do_reset();
    bp_en_i = 1'b1; bp_addr_i = 32'h10;
    tick(1, 0, 0);
    idle(8);
    check("bp_state", 32'(state_o), 32'd0);
    check("bp_cnt",   32'(instr_cnt_o), 32'd4);
    tick(1, 0, 0);
    idle(6);
    check("bp_resume_cnt", 32'(instr_cnt_o), 32'd10);
    bp_en_i = 1'b0;

    // End of program at 0x20; later requests are ignored.
    do_reset();
    imem[8] = 32'h8000_0000;
    tick(1, 0, 0);
    idle(12);
    tick(1, 0, 0); tick(0, 0, 1); tick(0, 1, 0); idle(2);
    check("end_done", 32'(done_o), 32'd1);
    check("end_cnt",  32'(instr_cnt_o), 32'd8);
    do_reset();
    check("end_rst_state", 32'(state_o), 32'd0);
    fill_clean();

    // run+step together in HALT gives one step.
    tick(1, 0, 1);
    idle(4);
    check("runstep_cnt", 32'(instr_cnt_o), 32'd1);

    // Asynchronous reset in the middle of a RUN cycle.
    do_reset();
    tick(1, 0, 0);
    idle(3);
    #2;
    check("pre_arst_en", 32'(core_en_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("arst_en",  32'(core_en_o), 32'd0);
    check("arst_cnt", 32'(instr_cnt_o), 32'd0);
    @(posedge clk); #1;
    do_reset();

    // Randomized programs, breakpoints and request streams.
    for (int round = 0; round < 5; round++) begin
      do_reset();
      fill_clean();
      for (int i = 4; i < 64; i++)
        if ($urandom_range(0, 30) == 0) imem[i] = 32'h8000_0000 | ($urandom & 32'h7FFF_E01F);
      bp_en_i   = $urandom_range(0, 1);
      bp_addr_i = 32'($urandom_range(0, 63)) << 2;
      for (int c = 0; c < 150; c++)
        tick($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end

    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
